// File: rtl/qbert_pkg.sv
// rtl/qbert_pkg.sv - shared controller state and level-mode encodings
package qbert_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    APPLY,
    COMPLETE,
    CLEAR
  } ctrl_state_t;

  localparam logic [1:0] MODE_SET    = 2'd0;
  localparam logic [1:0] MODE_TOGGLE = 2'd1;
  localparam logic [1:0] MODE_REVERT = 2'd2;

endpackage

// File: rtl/cube_color_controller_if.sv
// rtl/cube_color_controller_if.sv - game-logic side bus of the cube colour controller
interface cube_color_controller_if #(
  parameter int N_cube = 28,
  parameter int CNT_W  = $clog2(N_cube + 1)
);
  logic              game_start;
  logic [1:0]        level_mode;
  logic              done_move;
  logic [N_cube-1:0] position_qb;
  logic              enemy_land;
  logic [N_cube-1:0] enemy_pos;
  logic              level_ack;
  logic [N_cube-1:0] e_color_state;
  logic [CNT_W-1:0]  colored_cnt;
  logic              score_pulse;
  logic              level_done;
  logic              pos_error;

  modport master (
    output game_start, level_mode, done_move, position_qb, enemy_land, enemy_pos, level_ack,
    input  e_color_state, colored_cnt, score_pulse, level_done, pos_error
  );

  modport slave (
    input  game_start, level_mode, done_move, position_qb, enemy_land, enemy_pos, level_ack,
    output e_color_state, colored_cnt, score_pulse, level_done, pos_error
  );
endinterface

// File: rtl/onehot_check.sv
// rtl/onehot_check.sv - classifies a landing mask as empty or carrying more than one cube
module onehot_check #(
  parameter int N = 28
) (
  input  logic [N-1:0] mask,
  output logic         is_zero,
  output logic         is_multi
);
  assign is_zero  = (mask == '0);
  assign is_multi = ((mask & (mask - N'(1))) != '0);
endmodule

// File: rtl/cube_color_controller.sv
// rtl/cube_color_controller.sv - per-cube colour state, landing rules, cube count and level handshake
module cube_color_controller
  import qbert_pkg::*;
#(
  parameter int N_cube = 28,
  parameter int CNT_W  = $clog2(N_cube + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  cube_color_controller_if.slave  bus
);
  ctrl_state_t       state;
  logic [N_cube-1:0] bits, qb_pos_r, en_pos_r;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        mode_r;
  logic              qb_pend, en_pend, score_r, done_r, err_r;
  logic              qb_zero, qb_multi, en_zero, en_multi;

  onehot_check #(.N(N_cube)) u_qb_chk (.mask(qb_pos_r), .is_zero(qb_zero), .is_multi(qb_multi));
  onehot_check #(.N(N_cube)) u_en_chk (.mask(en_pos_r), .is_zero(en_zero), .is_multi(en_multi));

  logic [N_cube-1:0] mask, bits_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic              valid, multi, was_set, scored;
  logic              qb_take, en_take, qb_pend_nx, en_pend_nx;

  // Qbert has priority; the enemy event waits for the following APPLY cycle
  always_comb begin
    mask    = qb_pend ? qb_pos_r : en_pos_r;
    valid   = qb_pend ? (!qb_zero && !qb_multi) : (!en_zero && !en_multi);
    multi   = qb_pend ? qb_multi : en_multi;
    was_set = |(bits & mask);
    bits_nx = bits;
    cnt_nx  = cnt;
    scored  = 1'b0;
    if (valid) begin
      if (qb_pend) begin
        if (mode_r == MODE_TOGGLE) begin
          bits_nx = bits ^ mask;
          cnt_nx  = was_set ? cnt - CNT_W'(1) : cnt + CNT_W'(1);
          scored  = !was_set;
        end else if (!was_set) begin
          bits_nx = bits | mask;
          cnt_nx  = cnt + CNT_W'(1);
          scored  = 1'b1;
        end
      end else if (mode_r[1] && was_set) begin
        bits_nx = bits & ~mask;
        cnt_nx  = cnt - CNT_W'(1);
      end
    end
    // a landing during APPLY is kept only when its slot is free at the start of the cycle
    qb_take    = bus.done_move && !qb_pend;
    en_take    = bus.enemy_land && !en_pend;
    qb_pend_nx = qb_take;
    en_pend_nx = (qb_pend && en_pend) || en_take;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bits     <= '0;
      cnt      <= '0;
      qb_pos_r <= '0;
      en_pos_r <= '0;
      mode_r   <= MODE_SET;
      qb_pend  <= 1'b0;
      en_pend  <= 1'b0;
      score_r  <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      score_r <= 1'b0;
      case (state)
        IDLE: if (bus.game_start) state <= CLEAR;
        CLEAR: begin
          bits    <= '0;
          cnt     <= '0;
          qb_pend <= 1'b0;
          en_pend <= 1'b0;
          state   <= RUN;
        end
        RUN: begin
          if (bus.done_move) begin
            qb_pos_r <= bus.position_qb;
            qb_pend  <= 1'b1;
          end
          if (bus.enemy_land) begin
            en_pos_r <= bus.enemy_pos;
            en_pend  <= 1'b1;
          end
          if (bus.done_move || bus.enemy_land) begin
            mode_r <= bus.level_mode;
            state  <= APPLY;
          end
        end
        APPLY: begin
          bits    <= bits_nx;
          cnt     <= cnt_nx;
          score_r <= scored;
          if (multi) err_r <= 1'b1;
          if (qb_take) qb_pos_r <= bus.position_qb;
          if (en_take) en_pos_r <= bus.enemy_pos;
          qb_pend <= qb_pend_nx;
          en_pend <= en_pend_nx;
          if (qb_pend_nx || en_pend_nx) begin
            state <= APPLY;
          end else if (cnt_nx == CNT_W'(N_cube)) begin
            state  <= COMPLETE;
            done_r <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        COMPLETE: if (bus.level_ack) begin
          state  <= CLEAR;
          done_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.e_color_state = bits;
  assign bus.colored_cnt   = cnt;
  assign bus.score_pulse   = score_r;
  assign bus.level_done    = done_r;
  assign bus.pos_error     = err_r;
endmodule

// File: tb/tb_cube_color_controller.sv
// tb/tb_cube_color_controller.sv - directed and randomized checks against a cube-array reference model
module tb_cube_color_controller;
  localparam int N = 28;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cube_color_controller_if #(.N_cube(N)) bus ();
  cube_color_controller #(.N_cube(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  bit col [N];
  bit m_run, m_done, m_err;
  int m_mode;

  function automatic int m_count();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(col[i]);
    return s;
  endfunction

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = col[i];
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) col[i] = 1'b0;
  endtask

  task automatic model_event(input bit is_qb, input logic [N-1:0] m, output bit pulse);
    int ones = 0;
    int idx = 0;
    pulse = 1'b0;
    if (!m_run || m_done) return;
    for (int i = 0; i < N; i++) if (m[i]) begin ones++; idx = i; end
    if (ones > 1) m_err = 1'b1;
    if (ones != 1) return;
    if (is_qb) begin
      if (m_mode == 1) begin
        col[idx] = !col[idx];
        pulse = col[idx];
      end else if (!col[idx]) begin
        col[idx] = 1'b1;
        pulse = 1'b1;
      end
      if (m_count() == N) m_done = 1'b1;
    end else if (m_mode >= 2) begin
      col[idx] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit pulse);
    chk({tag, ".bits"}, 32'(bus.e_color_state), 32'(m_vec()));
    chk({tag, ".cnt"}, 32'(bus.colored_cnt), 32'(m_count()));
    chk({tag, ".score"}, 32'(bus.score_pulse), 32'(pulse));
    chk({tag, ".err"}, 32'(bus.pos_error), 32'(m_err));
    chk({tag, ".done"}, 32'(bus.level_done), 32'(m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int md);
    m_mode = md;
    bus.level_mode = 2'(md);
  endtask

  task automatic qb_land(input logic [N-1:0] m, input string tag);
    bit p;
    bus.position_qb = m;
    bus.done_move = 1'b1;
    tick();
    bus.done_move = 1'b0;
    tick();
    model_event(1'b1, m, p);
    check_all(tag, p);
  endtask

  task automatic en_land(input logic [N-1:0] m, input string tag);
    bit p;
    bus.enemy_pos = m;
    bus.enemy_land = 1'b1;
    tick();
    bus.enemy_land = 1'b0;
    tick();
    model_event(1'b0, m, p);
    check_all(tag, p);
  endtask

  task automatic start_level();
    bus.game_start = 1'b1;
    tick();
    bus.game_start = 1'b0;
    tick();
    m_run = 1'b1;
    m_clear();
  endtask

  task automatic ack_level(input string tag);
    bus.level_ack = 1'b1;
    tick();
    bus.level_ack = 1'b0;
    tick();
    if (m_done) begin
      m_done = 1'b0;
      m_clear();
    end
    check_all(tag, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    m_clear();
    m_run = 1'b0;
    m_done = 1'b0;
    m_err = 1'b0;
  endtask

  initial begin
    bit p;
    int order [N];
    logic [N-1:0] m;
    bus.game_start = 1'b0;
    bus.level_mode = 2'd0;
    bus.done_move = 1'b0;
    bus.position_qb = '0;
    bus.enemy_land = 1'b0;
    bus.enemy_pos = '0;
    bus.level_ack = 1'b0;
    m_clear();
    m_run = 1'b0; m_done = 1'b0; m_err = 1'b0; m_mode = 0;
    tick();
    check_all("reset", 1'b0);
    reset = 1'b1;
    tick();

    qb_land(28'h1, "idle_ignore");
    start_level();
    set_mode(0);
    qb_land(28'h1, "set_first");
    tick();
    chk("score_once", 32'(bus.score_pulse), 32'd0);
    qb_land(28'h1, "set_repeat");

    set_mode(1);
    qb_land(28'h20, "toggle_on");
    qb_land(28'h20, "toggle_off");

    set_mode(2);
    en_land(28'h1, "revert_clr0");
    qb_land(28'h8, "revert_set3");
    bus.position_qb = 28'h80; bus.done_move = 1'b1;
    bus.enemy_pos = 28'h8;    bus.enemy_land = 1'b1;
    tick();
    bus.done_move = 1'b0; bus.enemy_land = 1'b0;
    tick();
    model_event(1'b1, 28'h80, p);
    check_all("simul_qb", p);
    tick();
    model_event(1'b0, 28'h8, p);
    check_all("simul_en", p);

    set_mode(0);
    en_land(28'h80, "enemy_drop_set");
    qb_land(28'h3, "multi_bit");
    qb_land(28'h0, "zero_mask");
    ack_level("ack_in_run");

    do_reset();
    start_level();
    set_mode(0);
    for (int i = 0; i < N; i++) order[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      int j = int'($urandom_range(0, i));
      int t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < N; i++) begin
      m = '0;
      m[order[i]] = 1'b1;
      qb_land(m, "fill");
    end
    qb_land(28'h1 << 27, "complete_ignore");
    ack_level("ack_clear");
    qb_land(28'h10, "after_clear");

    for (int k = 0; k < 80; k++) begin
      int r = int'($urandom_range(0, 15));
      int a = int'($urandom_range(0, N - 1));
      set_mode(int'($urandom_range(0, 3)));
      m = '0;
      if (r == 0) begin
        m[a] = 1'b1;
        m[(a + 1 + int'($urandom_range(0, N - 2))) % N] = 1'b1;
      end else if (r != 1) begin
        m[a] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) en_land(m, "rand_en");
      else qb_land(m, "rand_qb");
      if (m_done) ack_level("rand_ack");
    end

    do_reset();
    start_level();
    set_mode(0);
    for (int i = 0; i < 10; i++) qb_land(28'h1 << i, "pre_reset");
    bus.position_qb = 28'h1 << 10;
    bus.done_move = 1'b1;
    tick();
    bus.done_move = 1'b0;
    reset = 1'b0;
    #1;
    m_clear(); m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
    check_all("async_reset", 1'b0);
    tick();
    reset = 1'b1;
    tick();
    qb_land(28'h1 << 11, "post_reset_idle");
    start_level();
    qb_land(28'h1 << 11, "post_reset_run");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cube_color_controller.md
Name: cube_color_controller

Overview:
- Owns the per-cube colour state of the pyramid and drives the e_color_state bus consumed by every cube renderer.
- Updates that state when Qbert lands (done_move) or when an enemy lands, applying the active level rule (set-once, toggle, or enemy revert).
- Counts coloured cubes, flags level completion, and handshakes with game logic before clearing for the next level.

Parameters:
- N_cube, 28, number of cubes in the pyramid (7 rows); width of all cube bitmasks.
- CNT_W, $clog2(N_cube+1), width of the coloured-cube counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- game_start  in  1  pulse; leaves IDLE and starts a level
- level_mode  in  2  0=SET (landing colours), 1=TOGGLE (landing inverts), 2/3=SET with enemy revert
- done_move  in  1  1-cycle pulse: Qbert jump finished
- position_qb  in  N_cube  one-hot landing cube of Qbert
- enemy_land  in  1  1-cycle pulse: enemy landed
- enemy_pos  in  N_cube  one-hot landing cube of enemy
- level_ack  in  1  game logic acknowledges level_done
- e_color_state  out  N_cube  colour bit per cube, 1=target colour
- colored_cnt  out  CNT_W  number of set bits in e_color_state
- score_pulse  out  1  1-cycle pulse when a cube turns 0->1 by Qbert
- level_done  out  1  high while in COMPLETE
- pos_error  out  1  sticky; a non-one-hot, non-zero position was sampled

Behaviour:
- Reset (async, low): state=IDLE, e_color_state=0, colored_cnt=0, score_pulse=0, level_done=0, pos_error=0, pending flags cleared.
- States: IDLE, RUN, APPLY, COMPLETE, CLEAR.
- IDLE: ignores done_move/enemy_land; game_start -> CLEAR.
- CLEAR (1 cycle): e_color_state=0, colored_cnt=0, pending flags cleared -> RUN.
- RUN:
  - done_move latches position_qb into qb_pos_r and sets qb_pend.
  - enemy_land latches enemy_pos into en_pos_r and sets en_pend.
  - Either pending flag set -> APPLY.
  - level_mode is sampled on entry to APPLY.
- APPLY (1 cycle per event):
  - qb_pend has priority: mask = qb_pos_r.
    - SET/revert modes: bits |= mask.
    - TOGGLE: bits ^= mask.
  - Else en_pend: in modes 2/3, bits &= ~mask; in modes 0/1 the event is dropped.
  - Served pending flag cleared. If the other flag is still set, APPLY repeats next cycle; else -> RUN, or -> COMPLETE if the new count == N_cube.
- Counter: updated incrementally in APPLY, +1 on a 0->1 bit, -1 on a 1->0 bit, no change otherwise. Never wraps; it is bounded 0..N_cube by construction.
- score_pulse: asserted in the cycle after APPLY produced a Qbert 0->1 change; never asserted for enemy events or toggle 1->0.
- Latency: done_move sampled at edge t -> qb_pend at t; APPLY during the next cycle -> e_color_state/colored_cnt updated at edge t+1, visible after t+1.
- Simultaneous done_move and enemy_land in RUN: both latched; Qbert applied first, enemy next cycle.
- done_move arriving during APPLY: latched (overwrites qb_pos_r only if qb_pend is already clear, else dropped); serviced on a later APPLY.
- Position validity: zero mask means no-op. A multi-bit mask is no-op and sets pos_error (cleared only by reset).
- COMPLETE:
  - level_done=1; done_move/enemy_land ignored.
  - level_ack -> CLEAR (next level starts automatically).
  - level_ack while not in COMPLETE is ignored.
- Reset mid-APPLY or mid-COMPLETE: immediate return to reset values; no partial update is kept.

Decomposition:
- Shared package qbert_pkg:
  - ctrl_state_t enum {IDLE, RUN, APPLY, COMPLETE, CLEAR}
  - level mode constants MODE_SET=2'd0, MODE_TOGGLE=2'd1, MODE_REVERT=2'd2
- One sub-module onehot_check (parameter N), combinational: flags is_zero and is_multi for a mask, instantiated for qb_pos_r and en_pos_r.

Test Plan:
- Reset then game_start, mode SET, done_move with position_qb=28'h1 -> after 1 cycle of APPLY: e_color_state=28'h1, colored_cnt=1, one score_pulse; repeat the same cube -> no change, no pulse.
- Mode TOGGLE, land twice on bit 5 -> bit 5 goes 1 then 0, colored_cnt 1 then 0, exactly one score_pulse.
- Mode REVERT, cube 3 coloured, same-cycle done_move on bit 7 and enemy_land on bit 3 -> bit 7 set first, then bit 3 cleared next cycle; final colored_cnt=1.
- Mode SET, land on all 28 cubes -> level_done=1 after the 28th APPLY; further done_move ignored; level_ack -> one CLEAR cycle, e_color_state=0, colored_cnt=0, state RUN.
- position_qb=28'h3 -> no colour change, pos_error=1 and stays 1; position_qb=0 -> no change, pos_error unchanged.
- Assert reset low during APPLY with 10 cubes coloured -> outputs are zero asynchronously; after release, state is IDLE and done_move is ignored until game_start.
